// File: rtl/counter_enable_ctrl.sv
// ---------------------------------------------------------------------------
// counter_enable_ctrl
//
// Run / pause / single-step controller for the LED counter stage. It cleans
// up the two DE0-Nano push-buttons, divides the board clock into a slow
// tick, and gates that tick through a three-mode state machine to form the
// counter's enable strobe. The counter's overflow flag comes back here so
// counting can stop on wrap.
//
// Parameters
//   DIV              prescaler period in clk cycles (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable samples to accept a level (>= 1)
//   STOP_ON_OVF      1: overflow forces HALT, 0: overflow ignored
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   btn_run_n   in   raw run/pause key, asynchronous, active-low
//   btn_step_n  in   raw single-step key, asynchronous, active-low
//   overflow    in   overflow flag from the counter stage
//   enable      out  registered one-cycle count strobe to the counter
//   state       out  current mode: PAUSE=00, RUN=01, HALT=10
//
// Handshake: there is no valid/ready pair. enable is a registered strobe
// that is high for exactly one clk cycle per count; the counter consumes it
// unconditionally. overflow is a level that is sampled every cycle.
// ---------------------------------------------------------------------------
module counter_enable_ctrl #(
  parameter int DIV             = 5_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STOP_ON_OVF     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run_n,
  input  logic       btn_step_n,
  input  logic       overflow,
  output logic       enable,
  output logic [1:0] state
);

  // Mode encodings; 2'b11 is illegal and falls back to PAUSE.
  localparam logic [1:0] ST_PAUSE = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  localparam int              PW       = $clog2(DIV);
  localparam logic [PW-1:0]   DIV_LAST = PW'(DIV - 1);

  // -------------------------------------------------------------------------
  // Button conditioning: synchronize, debounce, detect the press edge.
  // -------------------------------------------------------------------------
  logic run_level;
  logic run_press;
  logic step_level;
  logic step_press;

  counter_enable_ctrl_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_run_n),
    .level (run_level),
    .press (run_press)
  );

  counter_enable_ctrl_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_step_n),
    .level (step_level),
    .press (step_press)
  );

  // -------------------------------------------------------------------------
  // Mode FSM, prescaler and enable strobe.
  // -------------------------------------------------------------------------
  logic [1:0]    state_q;
  logic [1:0]    state_next;
  logic          enable_q;
  logic          enable_next;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_next;
  logic          tick;
  logic          ovf_stop;

  assign ovf_stop = (STOP_ON_OVF != 0) && overflow;

  // The tick only exists while running; the prescaler sits at 0 elsewhere.
  assign tick = (state_q == ST_RUN) && (presc_q == DIV_LAST);

  always_comb begin
    state_next  = state_q;
    enable_next = 1'b0;
    case (state_q)
      ST_PAUSE: begin
        // A run press wins over a simultaneous step press.
        if (run_press) begin
          state_next = ST_RUN;
        end else if (step_press) begin
          enable_next = 1'b1;
        end
      end
      ST_RUN: begin
        // Overflow beats a run press; step presses are ignored.
        if (ovf_stop) begin
          state_next = ST_HALT;
        end else if (run_press) begin
          state_next = ST_PAUSE;
        end
        // A tick on the edge that leaves RUN is dropped.
        enable_next = tick && (state_next == ST_RUN);
      end
      ST_HALT: begin
        if (run_press) begin
          state_next = ST_PAUSE;
        end
      end
      default: begin
        state_next = ST_PAUSE;
      end
    endcase
  end

  // Advance only while staying in RUN, so every entry into RUN starts from
  // a zero count and the first strobe lands DIV edges after entry.
  always_comb begin
    presc_next = '0;
    if ((state_q == ST_RUN) && (state_next == ST_RUN)) begin
      if (presc_q == DIV_LAST) begin
        presc_next = '0;
      end else begin
        presc_next = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PAUSE;
      enable_q <= 1'b0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_next;
      enable_q <= enable_next;
      presc_q  <= presc_next;
    end
  end

  assign enable = enable_q;
  assign state  = state_q;

  // The debounced levels are only consumed through their press edges.
  logic unused_levels;
  assign unused_levels = run_level ^ step_level;

endmodule

// ---------------------------------------------------------------------------
// counter_enable_ctrl_debounce
//
// Two-flop synchronizer followed by a stability counter for one active-low
// push-button, plus a one-cycle press pulse on each accepted 1->0 change.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous reset, active-high
//   raw    in   raw asynchronous button level (active-low)
//   level  out  debounced button level (1 = released)
//   press  out  combinational one-cycle pulse on a debounced 1->0 change
// ---------------------------------------------------------------------------
module counter_enable_ctrl_debounce #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  // The counter never holds CYCLES itself: the flip happens on the edge
  // where it would reach CYCLES, so it only needs to represent CYCLES-1.
  localparam int            DW       = (CYCLES < 2) ? 1 : $clog2(CYCLES);
  localparam logic [DW-1:0] CNT_LAST = DW'(CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d_q;
  logic [DW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      level_q   <= 1'b1;
      level_d_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      level_d_q <= level_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // This mismatching sample is number CYCLES in a row: accept it.
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  // Falling edge of the debounced level; releases produce nothing.
  assign press = level_d_q & ~level_q;

endmodule

// File: doc/counter_enable_ctrl.md
# counter_enable_ctrl

Run/pause/single-step controller that generates the `enable` strobe for the LED counter stage. It debounces the two DE0-Nano push-buttons, divides the 50 MHz board clock into a slow tick, and gates that tick through a small mode state machine. It sits directly upstream of the counter: `enable` drives the counter's enable input, and the counter's `overflow` is fed back here to halt counting.

## Interface

Parameters:
- `DIV`, default 5_000_000: prescaler period in clk cycles, giving 10 Hz at 50 MHz. Legal range is ≥2.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required to accept a button level (20 ms). Legal range is ≥1.
- `STOP_ON_OVF`, default 1: when 1, counter overflow forces HALT; when 0, overflow is ignored.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `btn_run_n`  in  1  raw run/pause key. Asynchronous; active-low.
- `btn_step_n`  in  1  raw single-step key. Asynchronous; active-low.
- `overflow`  in  1  overflow flag from the counter stage.
- `enable`  out  1  registered one-cycle count strobe to the counter.
- `state`  out  2  current mode: PAUSE=2'b00, RUN=2'b01, HALT=2'b10.

## Operation

- **Synchronizer.** Each button passes through a 2-flop synchronizer. Both flops reset to 1 (released).
- **Debouncer.** One per button.
  - A counter increments on every cycle where the synchronized value differs from the debounced value. It clears whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced value flips and the counter clears.
  - The debounced value resets to 1.
- **Press event.** A one-cycle combinational pulse on each debounced 1→0 transition. Releases generate nothing.
- **Prescaler.**
  - Width is $clog2(DIV). It counts 0..DIV-1 and wraps to 0.
  - It advances only in RUN and is held at 0 in any other state.
  - `tick` = (count == DIV-1) while in RUN.
- **FSM.** Resets to PAUSE.
  - PAUSE:
    - run press → RUN.
    - step press (without a run press) → one `enable` pulse; state stays PAUSE.
  - RUN:
    - `enable` follows `tick`.
    - `overflow`=1 with `STOP_ON_OVF`=1 → HALT.
    - Otherwise, run press → PAUSE.
    - Step presses are ignored.
  - HALT:
    - `enable` stays 0.
    - run press → PAUSE. Step presses are ignored.
  - The illegal encoding 2'b11 → PAUSE on the next edge.
- **Priorities.**
  - Run and step pressed in the same cycle in PAUSE: the run press wins and no step pulse is issued.
  - `overflow` and a run press in the same cycle in RUN: HALT wins.
  - Entering RUN while `overflow` is still high: HALT on the next edge.
- **Reset mid-operation.**
  - All registers return to their reset values on the next clk edge; any pending tick or pulse is dropped.
  - A button held through reset is treated as a new press `DEBOUNCE_CYCLES`+2 cycles after `rst` deasserts.

## Timing

- Reset values: `enable`=0 and `state`=2'b00. Prescaler and debounce counters are 0; synchronizer and debounced values are 1.
- Button latency:
  - Take edge 0 as the first edge that samples the raw button low.
  - The debounced value flips at edge 1+`DEBOUNCE_CYCLES`.
  - The FSM and `enable` update at edge 2+`DEBOUNCE_CYCLES`.
- A step press gives `enable` high for exactly one cycle.
- RUN timing:
  - If `state` becomes RUN at edge E, the first `enable` is high after edge E+`DIV`.
  - Subsequent strobes come every `DIV` cycles, each one cycle wide.
- Leaving RUN:
  - Leaving RUN at edge L means `enable` is 0 from edge L onward.
  - A tick coinciding with the leaving edge is dropped.
- Halt latency: `overflow` sampled high at edge k in RUN → `state`=HALT at edge k+1.

## Test plan

Use overrides `DIV`=4, `DEBOUNCE_CYCLES`=3, `STOP_ON_OVF`=1.

1. **Reset.** Hold `rst` for 2 cycles, then buttons released and `overflow`=0 for 50 cycles → `enable`=0 and `state`=00 throughout.
2. **Single step.** In PAUSE, hold `btn_step_n` low for 10 cycles, first sampled at edge 0 → exactly one `enable` pulse, high after edge 5; `state` stays 00.
3. **Bounce rejection.** Toggle `btn_run_n` every 2 cycles for 12 cycles, then release → no press event; `state` stays 00 and `enable` stays 0.
4. **Run/pause.**
   - Run press → `state`=01, then `enable` high 4 cycles later and every 4 cycles after that.
   - Second run press → `state`=00 and no further `enable`.
5. **Overflow halt.**
   - In RUN, pulse `overflow` for 1 cycle → `state`=10 on the next edge and `enable` stays 0.
   - Step press → no effect. Run press → `state`=00.
6. **Simultaneous press.** In PAUSE, press run and step in the same cycle → `state`=01 and no immediate `enable` pulse; the first strobe comes 4 cycles after RUN is entered.
